multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/mc_ctrl_decode.sv | 104 ++++++++++
 rtl/multicycle_ctrl.sv | 108 ++++++++++
 tb/tb_multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle processor control unit.
//   - state_t      : FSM state encodings (also exported on the debug state port)
//   - OP_*         : primary opcode values (IR[31:26]) the controller recognises
//   - ALUB_*       : alu_src_b select codes
//   - PCSRC_*      : pc_source select codes
//   - ALUOP_*      : alu_op codes
//   - waits_on_memory() : states that stall until mem_ready
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUB_B    = 2'd0;
  localparam logic [1:0] ALUB_FOUR = 2'd1;
  localparam logic [1:0] ALUB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // Memory-access states hold in place until the memory reports completion.
  function automatic logic waits_on_memory(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode for the multicycle controller.
// Inputs : state (current FSM state, 13-15 decode to all-zero),
//          mem_ready (memory completes this cycle), zero (ALU zero flag).
// Outputs: every datapath control line; anything not driven by a state is 0.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_shift,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal
);

  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_B;
    imm_shift  = 1'b0;
    alu_op     = ALUOP_ADD;
    pc_source  = PCSRC_ALU;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed, together
        // with the IR, in the cycle the instruction word actually arrives.
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target (PC + imm<<2) into ALUOut.
        alu_src_b = ALUB_IMM;
        imm_shift = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: state register and next-state logic.
// Inputs : clk, reset (sync, active-high), opcode (IR[31:26]),
//          zero (ALU zero flag), mem_ready (memory completes this cycle).
// Outputs: datapath controls (see mc_ctrl_decode), illegal (TRAP entry
//          pulse), state (debug view of the current FSM state).
// Parameter TRAP_ON_ILLEGAL: unknown opcodes go to TRAP (1) or FETCH (0).
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_shift,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  // Held as raw bits so the unused codes 13-15 remain representable and
  // are steered back to FETCH by the default arm below.
  logic [3:0] state_reg;
  logic [3:0] state_next;

  logic pc_en_dec, mem_read_dec, mem_write_dec;
  logic ir_write_dec, reg_write_dec, illegal_dec;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR, so anything other than lw is a store.
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = S_FETCH;
      S_EXEC:   state_next = S_RWB;
      S_RWB:    state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_TRAP:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
    if (waits_on_memory(state_reg) && !mem_ready) state_next = state_reg;
  end

  mc_ctrl_decode u_decode (
    .state      (state_reg),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pc_en      (pc_en_dec),
    .iord       (iord),
    .mem_read   (mem_read_dec),
    .mem_write  (mem_write_dec),
    .ir_write   (ir_write_dec),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write_dec),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_shift  (imm_shift),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal    (illegal_dec)
  );

  // Architectural side effects are suppressed in the same cycle reset is
  // seen, so an abandoned memory access never reaches the bus.
  assign pc_en     = pc_en_dec     & ~reset;
  assign mem_read  = mem_read_dec  & ~reset;
  assign mem_write = mem_write_dec & ~reset;
  assign ir_write  = ir_write_dec  & ~reset;
  assign reg_write = reg_write_dec & ~reset;
  assign illegal   = illegal_dec   & ~reset;
  assign state     = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, zero, mem_ready;
  logic [5:0] opcode_a, opcode_b;

  // dut_a: TRAP_ON_ILLEGAL=1, dut_b: TRAP_ON_ILLEGAL=0
  logic a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst;
  logic a_mem_to_reg, a_reg_write, a_alu_src_a, a_imm_shift, a_illegal;
  logic [1:0] a_alu_src_b, a_alu_op, a_pc_source;
  logic [3:0] a_state;
  logic b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst;
  logic b_mem_to_reg, b_reg_write, b_alu_src_a, b_imm_shift, b_illegal;
  logic [1:0] b_alu_src_b, b_alu_op, b_pc_source;
  logic [3:0] b_state;

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode_a), .zero(zero), .mem_ready(mem_ready),
    .pc_en(a_pc_en), .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .reg_write(a_reg_write), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .imm_shift(a_imm_shift), .alu_op(a_alu_op), .pc_source(a_pc_source),
    .illegal(a_illegal), .state(a_state)
  );

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode_b), .zero(zero), .mem_ready(mem_ready),
    .pc_en(b_pc_en), .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .imm_shift(b_imm_shift), .alu_op(b_alu_op), .pc_source(b_pc_source),
    .illegal(b_illegal), .state(b_state)
  );

  typedef struct packed {
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_shift;
    logic [1:0] alu_op, pc_source;
    logic       illegal;
  } ctrl_t;

  ctrl_t act_a, act_b;
  assign act_a = {a_pc_en, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg,
                  a_reg_write, a_alu_src_a, a_alu_src_b, a_imm_shift, a_alu_op, a_pc_source, a_illegal};
  assign act_b = {b_pc_en, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg,
                  b_reg_write, b_alu_src_a, b_alu_src_b, b_imm_shift, b_alu_op, b_pc_source, b_illegal};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instruction is the list of states it walks through; memory states
  // repeat while mem_ready is low. Index 0 models dut_a, index 1 dut_b.
  int         seq [2][8];
  int         seq_len [2];
  int         seq_pos [2];
  logic [5:0] op_cur [2];
  int         forced_op = -1;

  task automatic load(input int m, input int n, input int s2, input int s3, input int s4);
    seq[m][0] = 0; seq[m][1] = 1; seq[m][2] = s2; seq[m][3] = s3; seq[m][4] = s4;
    seq_len[m] = n;
    seq_pos[m] = 0;
  endtask

  task automatic build(input int m);
    logic [5:0] op;
    int r;
    if (forced_op >= 0) op = 6'(forced_op);
    else begin
      r = $urandom_range(0, 6);
      case (r)
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h02;
        5: op = 6'h08;
        default: op = 6'($urandom_range(0, 63));
      endcase
    end
    op_cur[m] = op;
    case (op)
      6'h00: load(m, 4, 6, 7, 0);
      6'h23: load(m, 5, 2, 3, 4);
      6'h2B: load(m, 4, 2, 5, 0);
      6'h04: load(m, 3, 8, 0, 0);
      6'h02: load(m, 3, 9, 0, 0);
      6'h08: load(m, 4, 10, 11, 0);
      default: if (m == 0) load(m, 3, 12, 0, 0); else load(m, 2, 0, 0, 0);
    endcase
  endtask

  function automatic int exp_state(input int m);
    return seq[m][seq_pos[m]];
  endfunction

  task automatic advance(input int m, input logic rst, input logic mr);
    int st;
    if (rst) build(m);
    else begin
      st = exp_state(m);
      if (!((st == 0 || st == 3 || st == 5) && !mr)) begin
        seq_pos[m]++;
        if (seq_pos[m] == seq_len[m]) build(m);
      end
    end
  endtask

  function automatic ctrl_t exp_ctrl(input int st, input logic mr, input logic z, input logic rst);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'd1; c.pc_en = mr; c.ir_write = mr; end
      1:  begin c.alu_src_b = 2'd2; c.imm_shift = 1; end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'd2; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_source = 2'd1; c.pc_en = z; end
      9:  begin c.pc_source = 2'd2; c.pc_en = 1; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
      11: begin c.reg_write = 1; end
      12: begin c.illegal = 1; end
      default: ;
    endcase
    if (rst) begin
      c.pc_en = 0; c.ir_write = 0; c.reg_write = 0;
      c.mem_read = 0; c.mem_write = 0; c.illegal = 0;
    end
    return c;
  endfunction

  // ---------------- cycle driver + compare ----------------
  logic [3:0] s_state, sb_state;
  logic       s_pc_en, s_ir_write, s_reg_write, s_mem_to_reg, s_mem_read, s_mem_write, s_illegal;
  logic [1:0] s_pc_source;
  int         ill_a = 0, ill_b = 0;

  task automatic step(input logic rst, input logic mr, input logic z);
    reset = rst; mem_ready = mr; zero = z;
    opcode_a = op_cur[0]; opcode_b = op_cur[1];
    #2;
    chk("state_a", 32'(a_state), 32'(exp_state(0)));
    chk("ctrl_a", 32'(act_a), 32'(exp_ctrl(exp_state(0), mr, z, rst)));
    chk("state_b", 32'(b_state), 32'(exp_state(1)));
    chk("ctrl_b", 32'(act_b), 32'(exp_ctrl(exp_state(1), mr, z, rst)));
    chk("rw_excl_a", 32'(a_mem_read & a_mem_write), 32'd0);
    chk("rw_excl_b", 32'(b_mem_read & b_mem_write), 32'd0);
    chk("alub_not3", 32'(a_alu_src_b == 2'd3 || b_alu_src_b == 2'd3), 32'd0);
    chk("pcsrc_not3", 32'(a_pc_source == 2'd3 || b_pc_source == 2'd3), 32'd0);
    s_state = a_state; sb_state = b_state;
    s_pc_en = a_pc_en; s_ir_write = a_ir_write; s_reg_write = a_reg_write;
    s_mem_to_reg = a_mem_to_reg; s_mem_read = a_mem_read; s_mem_write = a_mem_write;
    s_illegal = a_illegal; s_pc_source = a_pc_source;
    if (a_illegal) ill_a++;
    if (b_illegal) ill_b++;
    $display("cyc rst=%0d mr=%0d z=%0d opA=%02h stA=%0d opB=%02h stB=%0d", rst, mr, z,
             opcode_a, a_state, opcode_b, b_state);
    @(posedge clk);
    advance(0, rst, mr);
    advance(1, rst, mr);
    #1;
  endtask

  task automatic start(input int op);
    forced_op = op;
    step(1'b1, 1'b1, 1'b0);
  endtask

  int lat_ops [6] = '{'h00, 'h23, 'h2B, 'h04, 'h02, 'h08};
  int lat_exp [6] = '{4, 5, 4, 3, 3, 4};

  initial begin
    int cnt;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode_a = '0; opcode_b = '0;
    @(posedge clk);
    build(0); build(1);
    #1;

    // reset state
    start(-1);
    chk("rst_state", 32'(s_state), 32'd0);
    chk("rst_mem_read", 32'(s_mem_read), 32'd0);

    // lw, zero wait
    start('h23);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("lw_seq", 32'(s_state), 32'(i));
    end
    chk("lw_wb_regwrite", 32'(s_reg_write), 32'd1);
    chk("lw_wb_memtoreg", 32'(s_mem_to_reg), 32'd1);

    // FETCH with 3 wait cycles
    start('h23);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 3), 1'b0);
      chk("fetch_wait_state", 32'(s_state), 32'd0);
      chk("fetch_wait_irw", 32'(s_ir_write), 32'(i == 3));
      chk("fetch_wait_pcen", 32'(s_pc_en), 32'(i == 3));
    end

    // beq taken then not taken
    start('h04);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 1'b1, (k == 0));
        chk("beq_seq", 32'(s_state), (i == 2) ? 32'd8 : 32'(i));
      end
      chk("beq_pcen", 32'(s_pc_en), 32'(k == 0));
      chk("beq_pcsrc", 32'(s_pc_source), 32'd1);
    end

    // illegal opcode 0x3F, both parameter settings
    start('h3F);
    ill_a = 0; ill_b = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("ill_seq_a", 32'(s_state), (i == 2) ? 32'd12 : ((i == 3) ? 32'd0 : 32'(i)));
      chk("ill_seq_b", 32'(sb_state), 32'(i % 2));
    end
    chk("ill_pulses_a", 32'(ill_a), 32'd1);
    chk("ill_pulses_b", 32'(ill_b), 32'd0);

    // reset during a MEMWR wait
    start('h2B);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sw_wait_state", 32'(s_state), 32'd5);
    chk("sw_wait_memwrite", 32'(s_mem_write), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("sw_rst_memwrite", 32'(s_mem_write), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("sw_rst_state", 32'(s_state), 32'd0);
    chk("sw_rst_memwrite2", 32'(s_mem_write), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("post_rst_state", 32'(s_state), 32'd0);
    chk("post_rst_memread", 32'(s_mem_read), 32'd1);

    // zero-wait latency per instruction class
    for (int k = 0; k < 6; k++) begin
      start(lat_ops[k]);
      step(1'b0, 1'b1, 1'b0);
      cnt = 1;
      for (int g = 0; g < 20; g++) begin
        step(1'b0, 1'b1, 1'b0);
        if (s_state == 4'd0) break;
        cnt++;
      end
      chk("latency", 32'(cnt), 32'(lat_exp[k]));
    end

    // random stream
    forced_op = -1;
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
